// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) arbiter onto a single backing-memory port, one transaction in flight.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed dcache priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_resp_valid,
    output logic [LINE_WIDTH-1:0] i_resp_data,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic                  d_req_write,
    input  logic [LINE_WIDTH-1:0] d_req_wdata,
    output logic                  d_resp_valid,
    output logic [LINE_WIDTH-1:0] d_resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_write,
    output logic [LINE_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [LINE_WIDTH-1:0] mem_resp_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            state;
    logic                  owner_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] rdata_q;
    logic                  i_resp_q;
    logic                  d_resp_q;
    logic                  grant_i;
    logic                  grant_d;
    logic                  accept;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // prefer_i set means the icache wins the next tie (dcache was granted last)
    logic prefer_i;

    always_comb begin
        grant_d = d_req_valid && !(i_req_valid && prefer_i);
        grant_i = i_req_valid && !grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prefer_i <= 1'b0;
        else if (accept)
            prefer_i <= grant_d;
    end
`else
    always_comb begin
        grant_d = d_req_valid;
        grant_i = i_req_valid && !d_req_valid;
    end
`endif

    assign i_req_ready = (state == S_IDLE) && grant_i;
    assign d_req_ready = (state == S_IDLE) && grant_d;
    assign accept      = i_req_ready || d_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            owner_d  <= 1'b0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            i_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
        end else begin
            i_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner_d <= grant_d;
                        addr_q  <= grant_d ? d_req_addr : i_req_addr;
                        write_q <= grant_d && d_req_write;
                        wdata_q <= grant_d ? d_req_wdata : '0;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready)
                        state <= S_RESP;
                end
                S_RESP: begin
                    if (mem_resp_valid) begin
                        rdata_q  <= mem_resp_data;
                        i_resp_q <= !owner_d;
                        d_resp_q <= owner_d;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_req_valid = (state == S_REQ);
    assign mem_req_addr  = addr_q;
    assign mem_req_write = write_q;
    assign mem_req_wdata = wdata_q;
    assign i_resp_valid  = i_resp_q;
    assign d_resp_valid  = d_resp_q;
    assign i_resp_data   = rdata_q;
    assign d_resp_data   = rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width of all request ports.
REQ-002 Parameter LINE_WIDTH, default 128, width of refill/writeback data on all ports.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req_valid  input  1  icache miss request pending (read only).
REQ-006 i_req_ready  output  1  icache request accepted this cycle.
REQ-007 i_req_addr  input  ADDR_WIDTH  icache line address.
REQ-008 i_resp_valid  output  1  one-cycle pulse, icache read data valid.
REQ-009 i_resp_data  output  LINE_WIDTH  icache read line.
REQ-010 d_req_valid  input  1  dcache miss/writeback request pending.
REQ-011 d_req_ready  output  1  dcache request accepted this cycle.
REQ-012 d_req_addr  input  ADDR_WIDTH  dcache line address.
REQ-013 d_req_write  input  1  1 = writeback, 0 = refill read.
REQ-014 d_req_wdata  input  LINE_WIDTH  writeback line.
REQ-015 d_resp_valid  output  1  one-cycle pulse, dcache read data valid or write acknowledged.
REQ-016 d_resp_data  output  LINE_WIDTH  dcache read line; undefined content for writes.
REQ-017 mem_req_valid  output  1  request to backing memory.
REQ-018 mem_req_ready  input  1  memory accepts request.
REQ-019 mem_req_addr / mem_req_write / mem_req_wdata  output  ADDR_WIDTH / 1 / LINE_WIDTH  latched request fields.
REQ-020 mem_resp_valid  input  1  memory response/ack; mem_resp_data  input  LINE_WIDTH  read line.

Function
REQ-021 FSM states IDLE, REQ, RESP; exactly one transaction outstanding at any time.
REQ-022 IDLE: i_req_ready/d_req_ready combinational, high only for the arbitration winner among valid requesters; both low in REQ and RESP.
REQ-023 On acceptance (valid && ready) in cycle T: owner, addr, write (icache forced 0), wdata latched; state -> REQ; mem_req_valid high from T+1.
REQ-024 REQ: mem_req_valid and mem_req_* held stable until mem_req_ready sampled high; then state -> RESP, mem_req_valid low next cycle.
REQ-025 RESP: on mem_resp_valid, mem_resp_data latched; owner's resp_valid pulses exactly one cycle next cycle with data; state -> IDLE same edge.
REQ-026 New request acceptable in IDLE the cycle the resp_valid pulse is high (back-to-back: one idle arbitration cycle per transaction).
REQ-027 Writes also wait for mem_resp_valid; resp pulse goes to dcache with d_resp_data don't-care.
REQ-028 mem_resp_valid outside RESP ignored; mem_req_ready outside REQ ignored.
REQ-029 Requester dropping valid before acceptance: no grant, no state change.
REQ-030 Default arbitration fixed priority: dcache wins when both valid; icache starvation under continuous dcache traffic is permitted.
REQ-031 Non-owner resp_valid never asserted; resp_data outputs hold last latched line.

Reset
REQ-032 rst_n low: state IDLE, mem_req_valid 0, i/d_resp_valid 0, latched addr/data/write/owner 0, RR pointer -> dcache-preferred.
REQ-033 Reset mid-transaction aborts it; no response delivered for it after release.
REQ-034 First acceptance possible in first cycle after rst_n deasserts.

Configuration
REQ-035 Macro MEM_ARB_ROUND_ROBIN_EN defined: round-robin — when both valid, requester not granted last wins; single-bit pointer updated on each acceptance.
REQ-036 Macro undefined: fixed dcache priority per REQ-030; no pointer register.

Verification
REQ-037 Single icache read addr 0x0000_1000, mem_req_ready same cycle, mem_resp_valid 2 cycles later data 0xA5..A5 -> i_resp_valid one pulse, i_resp_data 0xA5..A5, mem_req_write 0.
REQ-038 Simultaneous i/d valid, d_req_write 1 addr 0x2000 -> d granted, mem_req_write 1, mem_req_wdata = d_req_wdata; icache served afterwards; with MEM_ARB_ROUND_ROBIN_EN, second simultaneous pair grants icache.
REQ-039 mem_req_ready held low 5 cycles -> mem_req_valid/addr stable all 5 cycles, no ready to requesters.
REQ-040 Spurious mem_resp_valid in IDLE and REQ -> no resp_valid pulse, state unchanged.
REQ-041 rst_n asserted in RESP then released, late mem_resp_valid -> no resp pulse, all outputs 0, next request served normally.
REQ-042 Continuous d traffic 20 transactions, fixed priority -> i_req_ready never high; round-robin -> grants alternate.
